// File: rtl/rf_wb_pkg.sv
// Shared types, default sizes and the pending-write lookup for the register-file writeback controller.
package rf_wb_pkg;

  localparam int ADDR  = 5;
  localparam int BUS_W = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [ADDR-1:0]  addr;
    logic [BUS_W-1:0] data;
  } wb_entry_t;

  // Entries presented oldest-first: index 0 is the head of the queue.
  typedef wb_entry_t [DEPTH-1:0] wb_bank_t;

  typedef struct packed {
    logic             hit;
    logic [BUS_W-1:0] data;
  } wb_match_t;

  localparam wb_entry_t ENTRY_ZERO = '{addr: {ADDR{1'b0}}, data: {BUS_W{1'b0}}};

  // Scanning oldest to youngest lets the youngest matching entry overwrite earlier hits.
  function automatic wb_match_t youngest_match(input wb_bank_t bank,
                                               input logic [DEPTH-1:0] valid,
                                               input logic [ADDR-1:0] addr);
    wb_match_t m;
    m.hit  = 1'b0;
    m.data = {BUS_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr != {ADDR{1'b0}}) && (bank[i].addr == addr)) begin
        m.hit  = 1'b1;
        m.data = bank[i].data;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Writeback entry queue: storage, head/tail pointers, occupancy and flush.
// Also exports every slot in age order with a valid mask for operand matching.
module rf_wb_fifo
  import rf_wb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  wb_entry_t                 push_entry,
  output wb_entry_t                 head_entry,
  output wb_bank_t                  entries,
  output logic [DEPTH-1:0]          valid,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Pointer, occupancy and storage update; storage is cleared on reset so the write port idles at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= {PW{1'b0}};
      tail  <= {PW{1'b0}};
      count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= ENTRY_ZERO;
      end
    end else if (flush) begin
      head  <= {PW{1'b0}};
      tail  <= {PW{1'b0}};
      count <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= tail + PW'(1'b1);
      end
      if (pop) begin
        head <= head + PW'(1'b1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1'b1);
        2'b01:   count <= count - CW'(1'b1);
        default: count <= count;
      endcase
    end
  end

  // Rotate storage so that slot 0 is the oldest entry; a slot is live when its age is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[head + PW'(i)];
      valid[i]   = (CW'(i) < count);
    end
  end

  assign head_entry = mem[head];
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == {CW{1'b0}});

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-side initiator: queues writeback results, drains one per cycle to the write port,
// and flags operands with pending writes. Define RF_WB_BYPASS_EN to forward queued data onto rs/rt_data.
module rf_writeback_ctrl #(
  parameter int ADDR  = rf_wb_pkg::ADDR,
  parameter int BUS_W = rf_wb_pkg::BUS_W,
  parameter int DEPTH = rf_wb_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR-1:0]          wb_addr,
  input  logic [BUS_W-1:0]         wb_data,
  input  logic                     flush,
  input  logic                     wr_hold,
  output logic [ADDR-1:0]          rf_rd_addr,
  output logic [BUS_W-1:0]         rf_rd_w_data,
  output logic                     rf_reg_write,
  input  logic [ADDR-1:0]          rs_addr,
  input  logic [ADDR-1:0]          rt_addr,
  input  logic [BUS_W-1:0]         rf_rs_data,
  input  logic [BUS_W-1:0]         rf_rt_data,
  output logic [BUS_W-1:0]         rs_data,
  output logic [BUS_W-1:0]         rt_data,
  output logic                     rs_busy,
  output logic                     rt_busy,
  output logic [$clog2(DEPTH):0]   count
);

  import rf_wb_pkg::*;

  wb_entry_t                   push_entry;
  wb_entry_t                   head_entry;
  wb_bank_t                    entries;
  logic [rf_wb_pkg::DEPTH-1:0] valid;
  logic                        full;
  logic                        empty;
  logic                        push;
  wb_match_t                   rs_match;
  wb_match_t                   rt_match;

  // Writes to r0 complete the handshake but never occupy a slot.
  assign wb_ready     = !full && !flush;
  assign push         = wb_valid && wb_ready && (wb_addr != {ADDR{1'b0}});
  assign rf_reg_write = !empty && !wr_hold && !flush;
  assign push_entry   = '{addr: wb_addr, data: wb_data};
  assign rf_rd_addr   = head_entry.addr;
  assign rf_rd_w_data = head_entry.data;

  rf_wb_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .pop        (rf_reg_write),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Pending-write lookup for both read operands.
  always_comb begin
    rs_match = youngest_match(entries, valid, rs_addr);
    rt_match = youngest_match(entries, valid, rt_addr);
  end

  assign rs_busy = rs_match.hit;
  assign rt_busy = rt_match.hit;

`ifdef RF_WB_BYPASS_EN
  // Forward the youngest uncommitted value when an operand is still pending.
  always_comb begin
    if (rs_match.hit) begin
      rs_data = rs_match.data;
    end else begin
      rs_data = rf_rs_data;
    end
    if (rt_match.hit) begin
      rt_data = rt_match.data;
    end else begin
      rt_data = rf_rt_data;
    end
  end
`else
  assign rs_data = rf_rs_data;
  assign rt_data = rf_rt_data;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_rf_writeback_ctrl;

  localparam int ADDR  = 5;
  localparam int BUS_W = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wb_valid = 1'b0;
  logic              wb_ready;
  logic [ADDR-1:0]   wb_addr = '0;
  logic [BUS_W-1:0]  wb_data = '0;
  logic              flush = 1'b0;
  logic              wr_hold = 1'b0;
  logic [ADDR-1:0]   rf_rd_addr;
  logic [BUS_W-1:0]  rf_rd_w_data;
  logic              rf_reg_write;
  logic [ADDR-1:0]   rs_addr = '0;
  logic [ADDR-1:0]   rt_addr = '0;
  logic [BUS_W-1:0]  rf_rs_data = '0;
  logic [BUS_W-1:0]  rf_rt_data = '0;
  logic [BUS_W-1:0]  rs_data;
  logic [BUS_W-1:0]  rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic [2:0]        count;

  int vectors = 0;
  int miscompares = 0;

  rf_writeback_ctrl dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .wr_hold(wr_hold),
    .rf_rd_addr(rf_rd_addr), .rf_rd_w_data(rf_rd_w_data), .rf_reg_write(rf_reg_write),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .rs_data(rs_data), .rt_data(rt_data), .rs_busy(rs_busy), .rt_busy(rt_busy), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending writes, oldest at index 0.
  typedef struct {
    logic [ADDR-1:0]  a;
    logic [BUS_W-1:0] d;
  } ent_t;
  ent_t q[$];

  function automatic logic m_busy(input logic [ADDR-1:0] a);
    if (a == 0) return 1'b0;
    foreach (q[i]) if (q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [BUS_W-1:0] m_data(input logic [ADDR-1:0] a, input logic [BUS_W-1:0] rf);
`ifdef RF_WB_BYPASS_EN
    if (a != 0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a == a) return q[i].d;
`endif
    return rf;
  endfunction

  // Apply the rules for the upcoming rising edge using the inputs currently driven.
  task automatic model_edge();
    logic acc, com;
    ent_t e;
    acc = wb_valid && (q.size() < DEPTH) && !flush;
    com = (q.size() > 0) && !wr_hold && !flush;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (com) q.delete(0);
      if (acc && wb_addr != 0) begin
        e.a = wb_addr;
        e.d = wb_data;
        q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if ({rf_reg_write, rf_rd_addr, rf_rd_w_data, count} !== {1'b0, 5'd0, 32'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs got we=%b a=%0d d=%h cnt=%0d want 0", rf_reg_write, rf_rd_addr, rf_rd_w_data, count);
    end
    vectors++;
    if (wb_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 1", wb_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_single();
    wr_hold = 1'b0; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (wb_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    vectors++;
    if ({rf_reg_write, rf_rd_addr, rf_rd_w_data, count} !== {1'b1, 5'd3, 32'hDEADBEEF, 3'd1}) begin
      miscompares++;
      $display("FAIL single_commit got we=%b a=%0d d=%h cnt=%0d want we=1 a=3 d=deadbeef cnt=1", rf_reg_write, rf_rd_addr, rf_rd_w_data, count);
    end
    tick();
    #1;
    vectors++;
    if ({rf_reg_write, count} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL single_drained got we=%b cnt=%0d want we=0 cnt=0", rf_reg_write, count);
    end
  endtask

  task automatic test_full();
    logic got5;
    wr_hold = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wb_valid = 1'b1; wb_addr = 5'(k); wb_data = 32'h100 + 32'(k);
      #1;
      vectors++;
      if ({wb_ready, count} !== {(k < 5), 3'(k - 1)}) begin
        miscompares++;
        $display("FAIL full_push%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d", k, wb_ready, count, (k < 5), k - 1);
      end
      tick();
    end
    wr_hold = 1'b0;
    got5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      vectors++;
      if ({rf_reg_write, rf_rd_addr, rf_rd_w_data} !== {1'b1, 5'(k), 32'h100 + 32'(k)}) begin
        miscompares++;
        $display("FAIL full_commit%0d got we=%b a=%0d d=%h want we=1 a=%0d", k, rf_reg_write, rf_rd_addr, rf_rd_w_data, k);
      end
      if (wb_valid && wb_ready) got5 = 1'b1;
      tick();
      if (got5) wb_valid = 1'b0;
    end
    #1;
    vectors++;
    if ({got5, count, rf_reg_write} !== {1'b1, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL full_after got acc5=%b cnt=%0d we=%b want acc5=1 cnt=0 we=0", got5, count, rf_reg_write);
    end
  endtask

  task automatic test_zero_addr();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; rs_addr = 5'd0;
    #1;
    vectors++;
    if ({wb_ready, rs_busy} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL zero_hs got rdy=%b rs_busy=%b want rdy=1 rs_busy=0", wb_ready, rs_busy);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    vectors++;
    if ({count, rf_reg_write} !== {3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL zero_dropped got cnt=%0d we=%b want cnt=0 we=0", count, rf_reg_write);
    end
  endtask

  task automatic test_bypass();
    logic [BUS_W-1:0] exp_rs;
    wr_hold = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
    tick();
    wb_data = 32'h22;
    tick();
    wb_valid = 1'b0; rs_addr = 5'd7; rf_rs_data = 32'h99; rt_addr = 5'd8; rf_rt_data = 32'h55;
`ifdef RF_WB_BYPASS_EN
    exp_rs = 32'h22;
`else
    exp_rs = 32'h99;
`endif
    #1;
    vectors++;
    if ({rs_busy, rt_busy, rs_data, rt_data} !== {1'b1, 1'b0, exp_rs, 32'h55}) begin
      miscompares++;
      $display("FAIL bypass got rs_busy=%b rt_busy=%b rs=%h rt=%h want 1 0 %h 55", rs_busy, rt_busy, rs_data, rt_data, exp_rs);
    end
    wr_hold = 1'b0;
    tick();
    tick();
    #1;
    vectors++;
    if ({rs_busy, count, rs_data} !== {1'b0, 3'd0, 32'h99}) begin
      miscompares++;
      $display("FAIL bypass_drain got rs_busy=%b cnt=%0d rs=%h want 0 0 99", rs_busy, count, rs_data);
    end
  endtask

  task automatic test_flush();
    wr_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1; wb_addr = 5'(10 + k); wb_data = $urandom();
      tick();
    end
    wb_addr = 5'd13; flush = 1'b1; wr_hold = 1'b0;
    #1;
    vectors++;
    if ({wb_ready, rf_reg_write, count} !== {1'b0, 1'b0, 3'd3}) begin
      miscompares++;
      $display("FAIL flush_cycle got rdy=%b we=%b cnt=%0d want 0 0 3", wb_ready, rf_reg_write, count);
    end
    tick();
    flush = 1'b0; wb_valid = 1'b0;
    #1;
    vectors++;
    if ({count, rf_reg_write} !== {3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_after got cnt=%0d we=%b want 0 0", count, rf_reg_write);
    end
  endtask

  task automatic test_back_to_back();
    logic [12+2*BUS_W-1:0] obs, exp;
    for (int n = 0; n < 500; n++) begin
      wb_valid   = ($urandom_range(0, 9) < 7);
      wb_addr    = 5'($urandom_range(0, 7));
      wb_data    = $urandom();
      wr_hold    = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 24) == 0);
      rs_addr    = 5'($urandom_range(0, 7));
      rt_addr    = 5'($urandom_range(0, 7));
      rf_rs_data = $urandom();
      rf_rt_data = $urandom();
      #1;
      obs = {wb_ready, rf_reg_write, count, rs_busy, rt_busy, 5'd0, rs_data, rt_data};
      exp = {(q.size() < DEPTH) && !flush, (q.size() > 0) && !wr_hold && !flush, 3'(q.size()),
             m_busy(rs_addr), m_busy(rt_addr), 5'd0, m_data(rs_addr, rf_rs_data), m_data(rt_addr, rf_rt_data)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL rand_outputs cycle %0d got %h want %h", n, obs, exp);
      end
      if (q.size() > 0) begin
        vectors++;
        if ({rf_rd_addr, rf_rd_w_data} !== {q[0].a, q[0].d}) begin
          miscompares++;
          $display("FAIL rand_head cycle %0d got a=%0d d=%h want a=%0d d=%h", n, rf_rd_addr, rf_rd_w_data, q[0].a, q[0].d);
        end
      end
      tick();
    end
    wb_valid = 1'b0; flush = 1'b0; wr_hold = 1'b0;
    for (int n = 0; n < DEPTH + 1; n++) tick();
  endtask

  task automatic test_reset_mid();
    wr_hold = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'hA0A0;
    tick();
    wb_addr = 5'd21; wb_data = 32'hB1B1;
    tick();
    wb_valid = 1'b0; wr_hold = 1'b0;
    #1;
    vectors++;
    if ({rf_reg_write, count} !== {1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL midreset_pre got we=%b cnt=%0d want 1 2", rf_reg_write, count);
    end
    #1;
    reset = 1'b1;
    q.delete();
    #1;
    vectors++;
    if ({rf_reg_write, rf_rd_addr, rf_rd_w_data, count} !== {1'b0, 5'd0, 32'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL midreset_async got we=%b a=%0d d=%h cnt=%0d want 0", rf_reg_write, rf_rd_addr, rf_rd_w_data, count);
    end
    tick();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      vectors++;
      if ({rf_reg_write, count} !== {1'b0, 3'd0}) begin
        miscompares++;
        $display("FAIL midreset_after%0d got we=%b cnt=%0d want 0 0", n, rf_reg_write, count);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_zero_addr();
    test_bypass();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
